mem_stage: RTL and testbench

- Memory-access pipeline stage, directly downstream of the execute stage; consumes the 190-bit EX→MEM bus and the synchronous data-SRAM read data.
- Performs load byte/half extraction and sign/zero extension, then selects the load or execute result as the final value.
- Drives the MEM→WB bus, forwarding/hazard info to decode, and an exception indication back to execute that suppresses stores behind a faulting instruction.
- Keeps SRAM read data across writeback back-pressure.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_stage_if.sv | 11 +
 rtl/mem_stage_load_ext.sv | 39 +++
 rtl/mem_stage.sv | 119 +++++++++++
 tb/tb_mem_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the memory-access stage: bus widths, EX->MEM field
// offsets and the load-type encoding carried in mem_type.
package mem_pkg;

   localparam int EXMEM_W = 190;
   localparam int MEMWB_W = 184;
   localparam int MEMID_W = 53;

   // EX->MEM bus field positions (LSB of each field)
   localparam int EX_SYSCALL      = 0;
   localparam int EX_ERTN         = 1;
   localparam int EX_CSR_WVALUE   = 2;
   localparam int EX_CSR_WMASK    = 34;
   localparam int EX_CSR_NUM      = 66;
   localparam int EX_CSR_RE       = 80;
   localparam int EX_CSR_WE       = 81;
   localparam int EX_RESULT       = 82;
   localparam int EX_INST         = 114;
   localparam int EX_PC           = 146;
   localparam int EX_DEST         = 178;
   localparam int EX_ADDR_LOW2    = 183;
   localparam int EX_MEM_TYPE     = 185;
   localparam int EX_RES_FROM_MEM = 188;
   localparam int EX_GR_WE        = 189;

   localparam logic [2:0] MEM_TYPE_LD_W  = 3'b000;
   localparam logic [2:0] MEM_TYPE_LD_B  = 3'b001;
   localparam logic [2:0] MEM_TYPE_LD_H  = 3'b010;
   localparam logic [2:0] MEM_TYPE_LD_BU = 3'b011;
   localparam logic [2:0] MEM_TYPE_LD_HU = 3'b100;

endpackage

// File: rtl/mem_stage_if.sv
// Valid/allowin pipeline handshake carrying a W-bit payload bus between stages.
interface mem_stage_if #(parameter int W = 32);

   logic         valid;
   logic [W-1:0] bus;
   logic         allowin;

   modport master (output valid, output bus, input allowin);
   modport slave  (input valid, input bus, output allowin);

endinterface

// File: rtl/mem_stage_load_ext.sv
// Load data extraction: picks the addressed byte/half from the read word and
// sign- or zero-extends it according to the load type.
module load_ext
   import mem_pkg::*;
(
   input  logic [2:0]  mem_type,
   input  logic [1:0]  addr_low2,
   input  logic [31:0] rdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_low2)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
   end

   assign half_sel = addr_low2[1] ? rdata[31:16] : rdata[15:0];

   // Unused encodings fall back to a full-word load.
   always_comb begin
      load_data = rdata;
      case (mem_type)
         MEM_TYPE_LD_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
         MEM_TYPE_LD_BU: load_data = {24'd0, byte_sel};
         MEM_TYPE_LD_H:  load_data = {{16{half_sel[15]}}, half_sel};
         MEM_TYPE_LD_HU: load_data = {16'd0, half_sel};
         default:        load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX->MEM bus, finishes loads from
// SRAM read data (held across writeback stalls) and feeds writeback and decode.
module mem_stage
   import mem_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   mem_stage_if.slave         ex_mem,
   input  logic [31:0]        data_sram_rdata,
   mem_stage_if.master        mem_wb,
   output logic [MEMID_W-1:0] mem_id_bus,
   output logic               mem_ex,
   input  logic               wb_ex,
   input  logic               ertn_flush
);

   logic               mem_valid;
   logic               hold_vld;
   logic [EXMEM_W-1:0] bus_q;
   logic [31:0]        rdata_hold;

   logic        flush;
   logic        allowin;
   logic        capture;
   logic [31:0] rdata_src;
   logic [31:0] load_data;
   logic [31:0] final_result;

   logic        gr_we;
   logic        res_from_mem;
   logic [2:0]  mem_type;
   logic [1:0]  addr_low2;
   logic [4:0]  dest;
   logic [31:0] pc;
   logic [31:0] inst;
   logic [31:0] result;
   logic        csr_we;
   logic        csr_re;
   logic [13:0] csr_num;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;
   logic        ertn;
   logic        syscall;

   assign flush   = wb_ex | ertn_flush;
   assign allowin = ~mem_valid | mem_wb.allowin;
   assign capture = mem_valid & ~mem_wb.allowin & ~hold_vld;

   assign ex_mem.allowin = allowin;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         mem_valid <= 1'b0;
      else if (flush)
         mem_valid <= 1'b0;
      else if (allowin)
         mem_valid <= ex_mem.valid;
   end

   // NOTE: payload registers carry no reset; they are only observed while
   // the matching valid/hold flag is set, so reset state would be dead logic.
   always_ff @(posedge clk) begin
      if (ex_mem.valid & allowin)
         bus_q <= ex_mem.bus;
   end

   // Read data is only valid in the first MEM cycle, so snapshot it on stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         hold_vld <= 1'b0;
      else if (flush | (mem_valid & mem_wb.allowin))
         hold_vld <= 1'b0;
      else if (capture)
         hold_vld <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (capture)
         rdata_hold <= data_sram_rdata;
   end

   assign gr_we        = bus_q[EX_GR_WE];
   assign res_from_mem = bus_q[EX_RES_FROM_MEM];
   assign mem_type     = bus_q[EX_MEM_TYPE +: 3];
   assign addr_low2    = bus_q[EX_ADDR_LOW2 +: 2];
   assign dest         = bus_q[EX_DEST +: 5];
   assign pc           = bus_q[EX_PC +: 32];
   assign inst         = bus_q[EX_INST +: 32];
   assign result       = bus_q[EX_RESULT +: 32];
   assign csr_we       = bus_q[EX_CSR_WE];
   assign csr_re       = bus_q[EX_CSR_RE];
   assign csr_num      = bus_q[EX_CSR_NUM +: 14];
   assign csr_wmask    = bus_q[EX_CSR_WMASK +: 32];
   assign csr_wvalue   = bus_q[EX_CSR_WVALUE +: 32];
   assign ertn         = bus_q[EX_ERTN];
   assign syscall      = bus_q[EX_SYSCALL];

   assign rdata_src = hold_vld ? rdata_hold : data_sram_rdata;

   load_ext u_load_ext (
      .mem_type  (mem_type),
      .addr_low2 (addr_low2),
      .rdata     (rdata_src),
      .load_data (load_data)
   );

   assign final_result = res_from_mem ? load_data : result;

   assign mem_wb.valid = mem_valid;
   assign mem_wb.bus   = {gr_we, dest, pc, inst, final_result, csr_we, csr_re,
                          csr_num, csr_wmask, csr_wvalue, ertn, syscall};

   // mem_csr is left ungated; decode qualifies it with the bypass bit.
   assign mem_id_bus = {mem_valid & gr_we, dest, final_result,
                        csr_we | csr_re, csr_num};

   assign mem_ex = mem_valid & (ertn | syscall);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extension, stall hold, forwarding,
// flush and asynchronous reset behaviour with hand-computed expectations.
module tb_mem_stage;
   import mem_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic [31:0]        data_sram_rdata;
   logic [MEMID_W-1:0] mem_id_bus;
   logic               mem_ex;
   logic               wb_ex;
   logic               ertn_flush;

   int n_checks = 0;
   int n_fail   = 0;
   int xfers    = 0;

   mem_stage_if #(.W(EXMEM_W)) ex_mem ();
   mem_stage_if #(.W(MEMWB_W)) mem_wb ();

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ex_mem          (ex_mem),
      .data_sram_rdata (data_sram_rdata),
      .mem_wb          (mem_wb),
      .mem_id_bus      (mem_id_bus),
      .mem_ex          (mem_ex),
      .wb_ex           (wb_ex),
      .ertn_flush      (ertn_flush)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_wb.valid && mem_wb.allowin)
         xfers <= xfers + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [EXMEM_W-1:0] make_bus(
      input logic gr_we, input logic rfm, input logic [2:0] mtype,
      input logic [1:0] addr, input logic [4:0] dest, input logic [31:0] result,
      input logic syscall);
      return {gr_we, rfm, mtype, addr, dest, 32'h1c00_0100, 32'h2880_0000,
              result, 1'b0, 1'b0, 14'd0, 32'd0, 32'd0, 1'b0, syscall};
   endfunction

   // Present one load, let it enter MEM, drive its read data, check the result.
   task automatic do_load(input string tag, input logic [2:0] mtype,
                          input logic [1:0] addr, input logic [31:0] rdata,
                          input logic [31:0] exp);
      ex_mem.valid = 1'b1;
      ex_mem.bus   = make_bus(1'b1, 1'b1, mtype, addr, 5'd3, 32'h0, 1'b0);
      tick();
      ex_mem.valid    = 1'b0;
      data_sram_rdata = rdata;
      #1;
      check({tag, "_valid"}, {31'd0, mem_wb.valid}, 32'd1);
      check(tag, mem_wb.bus[113:82], exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset           = 1'b1;
      ex_mem.valid    = 1'b0;
      ex_mem.bus      = '0;
      mem_wb.allowin  = 1'b0;
      data_sram_rdata = 32'h0;
      wb_ex           = 1'b0;
      ertn_flush      = 1'b0;
      tick();
      tick();
      check("rst_valid",   {31'd0, mem_wb.valid},   32'd0);
      check("rst_mem_ex",  {31'd0, mem_ex},         32'd0);
      check("rst_bypass",  {31'd0, mem_id_bus[52]}, 32'd0);
      check("rst_allowin", {31'd0, ex_mem.allowin}, 32'd1);
      reset          = 1'b0;
      mem_wb.allowin = 1'b1;

      // Back-to-back loads, no back-pressure
      do_load("ld_b",    MEM_TYPE_LD_B,  2'd3, 32'h8012_3456, 32'hFFFF_FF80);
      check("b2b_hold0", {31'd0, dut.hold_vld}, 32'd0);
      do_load("ld_bu",   MEM_TYPE_LD_BU, 2'd3, 32'h8012_3456, 32'h0000_0080);
      do_load("ld_b_a1", MEM_TYPE_LD_B,  2'd1, 32'h8012_3456, 32'h0000_0034);
      do_load("ld_hu",   MEM_TYPE_LD_HU, 2'd2, 32'hBEEF_1234, 32'h0000_BEEF);
      do_load("ld_h",    MEM_TYPE_LD_H,  2'd2, 32'hBEEF_1234, 32'hFFFF_BEEF);
      do_load("ld_h_a0", MEM_TYPE_LD_H,  2'd0, 32'hBEEF_9234, 32'hFFFF_9234);
      do_load("ld_w",    MEM_TYPE_LD_W,  2'd0, 32'h1357_9BDF, 32'h1357_9BDF);
      do_load("ld_rsvd", 3'b111,         2'd3, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
      check("b2b_hold1", {31'd0, dut.hold_vld}, 32'd0);
      tick();
      check("drain_valid", {31'd0, mem_wb.valid}, 32'd0);

      // Stall: read data changes while writeback is blocked
      ex_mem.valid = 1'b1;
      ex_mem.bus   = make_bus(1'b1, 1'b1, MEM_TYPE_LD_W, 2'd0, 5'd7, 32'h0, 1'b0);
      tick();
      ex_mem.valid    = 1'b0;
      data_sram_rdata = 32'hCAFE_F00D;
      mem_wb.allowin  = 1'b0;
      #1;
      check("stall_allowin0", {31'd0, ex_mem.allowin}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         data_sram_rdata = 32'hDEAD_DEAD;
         #1;
         check("stall_allowin", {31'd0, ex_mem.allowin}, 32'd0);
         check("stall_result",  mem_wb.bus[113:82],      32'hCAFE_F00D);
      end
      xfers          = 0;
      mem_wb.allowin = 1'b1;
      #1;
      check("release_valid",  {31'd0, mem_wb.valid}, 32'd1);
      check("release_result", mem_wb.bus[113:82],     32'hCAFE_F00D);
      tick();
      tick();
      check("release_xfers", xfers, 32'd1);
      check("release_hold",  {31'd0, dut.hold_vld}, 32'd0);

      // Non-load forwarding
      ex_mem.valid = 1'b1;
      ex_mem.bus   = make_bus(1'b1, 1'b0, MEM_TYPE_LD_W, 2'd0, 5'd5, 32'h0000_1234, 1'b0);
      tick();
      ex_mem.valid = 1'b0;
      check("fwd_bypass", {31'd0, mem_id_bus[52]}, 32'd1);
      check("fwd_dest",   {27'd0, mem_id_bus[51:47]}, 32'd5);
      check("fwd_result", mem_id_bus[46:15], 32'h0000_1234);
      check("fwd_wb_dest", {27'd0, mem_wb.bus[182:178]}, 32'd5);
      check("fwd_mem_ex", {31'd0, mem_ex}, 32'd0);
      ex_mem.valid = 1'b1;
      ex_mem.bus   = make_bus(1'b0, 1'b0, MEM_TYPE_LD_W, 2'd0, 5'd5, 32'h0000_1234, 1'b0);
      tick();
      ex_mem.valid = 1'b0;
      check("nofwd_bypass", {31'd0, mem_id_bus[52]}, 32'd0);

      // Syscall raises mem_ex; flush drops the instruction arriving alongside it
      ex_mem.valid = 1'b1;
      ex_mem.bus   = make_bus(1'b0, 1'b0, MEM_TYPE_LD_W, 2'd0, 5'd0, 32'h0, 1'b1);
      tick();
      check("sys_mem_ex", {31'd0, mem_ex}, 32'd1);
      ex_mem.bus = make_bus(1'b1, 1'b0, MEM_TYPE_LD_W, 2'd0, 5'd9, 32'h9999, 1'b0);
      wb_ex      = 1'b1;
      tick();
      wb_ex        = 1'b0;
      ex_mem.valid = 1'b0;
      check("flush_valid",  {31'd0, mem_wb.valid},   32'd0);
      check("flush_hold",   {31'd0, dut.hold_vld},   32'd0);
      check("flush_mem_ex", {31'd0, mem_ex},         32'd0);
      tick();
      check("flush_dropped", {31'd0, mem_wb.valid},  32'd0);

      // Flush while stalled discards the instruction and its held data
      ex_mem.valid = 1'b1;
      ex_mem.bus   = make_bus(1'b1, 1'b1, MEM_TYPE_LD_W, 2'd0, 5'd4, 32'h0, 1'b0);
      tick();
      ex_mem.valid   = 1'b0;
      mem_wb.allowin = 1'b0;
      tick();
      check("stall2_hold", {31'd0, dut.hold_vld}, 32'd1);
      ertn_flush = 1'b1;
      tick();
      ertn_flush = 1'b0;
      check("ertn_valid", {31'd0, mem_wb.valid}, 32'd0);
      check("ertn_hold",  {31'd0, dut.hold_vld}, 32'd0);

      // Asynchronous reset in the middle of a stall
      ex_mem.valid = 1'b1;
      ex_mem.bus   = make_bus(1'b1, 1'b1, MEM_TYPE_LD_W, 2'd0, 5'd6, 32'h0, 1'b0);
      tick();
      ex_mem.valid    = 1'b0;
      data_sram_rdata = 32'h1111_1111;
      tick();
      check("rst2_hold_pre", {31'd0, dut.hold_vld}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rst2_valid",   {31'd0, mem_wb.valid},   32'd0);
      check("rst2_mem_ex",  {31'd0, mem_ex},         32'd0);
      check("rst2_allowin", {31'd0, ex_mem.allowin}, 32'd1);
      tick();
      reset          = 1'b0;
      mem_wb.allowin = 1'b1;
      do_load("post_rst_ld", MEM_TYPE_LD_W, 2'd0, 32'h2222_2222, 32'h2222_2222);
      check("post_rst_hold", {31'd0, dut.hold_vld}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
